// File: rtl/tt_checker_pkg.sv
// Shared types for the truth-table response checker: FSM states, default table, saturating add.
// Combinational helpers only; no latency, no backpressure.
package tt_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit i is the expected output of a 3-input OR for input vector i.
  localparam logic [7:0] TRUTH_OR3 = 8'hFE;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    if (val >= max_val) begin
      return max_val;
    end
    return val + 32'd1;
  endfunction

endpackage

// File: rtl/tt_coverage_map.sv
// Set/clear bitmap of checked vectors with a look-ahead all-ones detect.
// Map updates one cycle after set/clr; full_nxt is combinational; no backpressure.
module tt_coverage_map #(
  parameter int IDX_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    set_en,
  input  logic [IDX_W-1:0]        set_idx,
  output logic [(1<<IDX_W)-1:0]   map,
  output logic                    full_nxt
);

  logic [(1<<IDX_W)-1:0] map_nxt;

  // Clear takes priority so a restart drops any coincident set.
  always_comb begin
    map_nxt = map;
    if (clr) begin
      map_nxt = '0;
    end else if (set_en) begin
      map_nxt[set_idx] = 1'b1;
    end
  end

  assign full_nxt = &map_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map <= '0;
    end else begin
      map <= map_nxt;
    end
  end

endmodule

// File: rtl/tt_response_checker.sv
// Checks observed gate outputs against a truth table, tracks coverage and counts mismatches.
// Results visible the cycle after accept; vec_ready high only in RUN (one vector per cycle).
// Optional first-mismatch capture ports when TT_CHECK_FIRST_FAIL_EN is defined.
module tt_response_checker
  import tt_checker_pkg::*;
#(
  parameter int                  N_IN  = 3,
  parameter logic [(1<<N_IN)-1:0] TRUTH = TRUTH_OR3,
  parameter int                  CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  vec_valid,
  input  logic [N_IN-1:0]       vec_in,
  input  logic                  dut_out,
  output logic                  vec_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [(1<<N_IN)-1:0]  cov_map,
  output logic [CNT_W-1:0]      err_cnt
`ifdef TT_CHECK_FIRST_FAIL_EN
  ,
  output logic                  first_fail_valid,
  output logic [N_IN-1:0]       first_fail_vec
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state, state_nxt;
  logic   accept;
  logic   mismatch;
  logic   cov_full_nxt;

  // A start in the same cycle as a vector clears results and drops the vector.
  assign accept   = vec_valid && vec_ready && !start;
  assign mismatch = (dut_out != TRUTH[vec_in]);

  tt_coverage_map #(
    .IDX_W (N_IN)
  ) u_cov (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (start),
    .set_en   (accept),
    .set_idx  (vec_in),
    .map      (cov_map),
    .full_nxt (cov_full_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        if (start) begin
          state_nxt = ST_RUN;
        end else if (accept && cov_full_nxt) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: if (start) state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign vec_ready = (state == ST_RUN);
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign pass      = done && (err_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (start) begin
      err_cnt <= '0;
    end else if (accept && mismatch) begin
      err_cnt <= CNT_W'(sat_inc(32'(err_cnt), 32'(CNT_MAX)));
    end
  end

`ifdef TT_CHECK_FIRST_FAIL_EN
  // Capture only the earliest mismatch since the last start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else if (start) begin
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else if (accept && mismatch && !first_fail_valid) begin
      first_fail_valid <= 1'b1;
      first_fail_vec   <= vec_in;
    end
  end
`endif

endmodule

// File: tb/tb_tt_response_checker.sv
// Randomised and directed bench for tt_response_checker against a behavioural OR-gate model.
module tb_tt_response_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       vec_valid;
  logic [2:0] vec_in;
  logic       dut_out;

  logic       vec_ready, busy, done, pass;
  logic [7:0] cov_map;
  logic [7:0] err_cnt;
  logic       s_vec_ready, s_busy, s_done, s_pass;
  logic [7:0] s_cov_map;
  logic [1:0] s_err_cnt;
`ifdef TT_CHECK_FIRST_FAIL_EN
  logic       ff_valid, s_ff_valid;
  logic [2:0] ff_vec, s_ff_vec;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: what has been seen since start, at the level of the spec's rules.
  logic       m_run;
  logic       m_done;
  logic [7:0] m_cov;
  int         m_err;
  logic       m_ffv;
  logic [2:0] m_ffvec;

  always #5 clk = ~clk;

  tt_response_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid),
    .vec_in(vec_in), .dut_out(dut_out), .vec_ready(vec_ready), .busy(busy),
    .done(done), .pass(pass), .cov_map(cov_map), .err_cnt(err_cnt)
`ifdef TT_CHECK_FIRST_FAIL_EN
    , .first_fail_valid(ff_valid), .first_fail_vec(ff_vec)
`endif
  );

  tt_response_checker #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid),
    .vec_in(vec_in), .dut_out(dut_out), .vec_ready(s_vec_ready), .busy(s_busy),
    .done(s_done), .pass(s_pass), .cov_map(s_cov_map), .err_cnt(s_err_cnt)
`ifdef TT_CHECK_FIRST_FAIL_EN
    , .first_fail_valid(s_ff_valid), .first_fail_vec(s_ff_vec)
`endif
  );

  function automatic logic [7:0] exp_err8();
    return (m_err > 255) ? 8'd255 : 8'(m_err);
  endfunction

  function automatic logic [1:0] exp_err2();
    return (m_err > 3) ? 2'd3 : 2'(m_err);
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_done = 1'b0; m_cov = '0; m_err = 0; m_ffv = 1'b0; m_ffvec = '0;
  endtask

  // Drive one cycle of stimulus, advance the model at the edge, sample 1 time unit later.
  task automatic step(input logic [2:0] v, input logic o, input logic vld, input logic strt);
    start = strt; vec_valid = vld; vec_in = v; dut_out = o;
    @(posedge clk);
    if (strt) begin
      model_reset();
      m_run = 1'b1;
    end else if (vld && m_run) begin
      if (o != (|v)) begin
        m_err++;
        if (!m_ffv) begin m_ffv = 1'b1; m_ffvec = v; end
      end
      m_cov[v] = 1'b1;
      if (m_cov == 8'hFF) begin m_run = 1'b0; m_done = 1'b1; end
    end
    #1;
    start = 1'b0; vec_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; vec_valid = 1'b0; vec_in = '0; dut_out = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({vec_ready, busy, done, pass} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {vec_ready, busy, done, pass});
    end
    checks++;
    if (cov_map !== 8'h00 || err_cnt !== 8'h00) begin
      errors++; $display("FAIL reset_results cov=%h err=%0d want 00/0", cov_map, err_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive();
    step(3'd0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (busy !== 1'b1 || vec_ready !== 1'b1) begin
      errors++; $display("FAIL exh_start busy=%b ready=%b want 1/1", busy, vec_ready);
    end
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      step(v, |v, 1'b1, 1'b0);
      if (i < 7) begin
        checks++;
        if (done !== 1'b0 || cov_map !== m_cov) begin
          errors++; $display("FAIL exh_progress i=%0d done=%b cov=%h want 0/%h", i, done, cov_map, m_cov);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || vec_ready !== 1'b0) begin
      errors++; $display("FAIL exh_done done=%b pass=%b ready=%b want 1/1/0", done, pass, vec_ready);
    end
    checks++;
    if (err_cnt !== 8'd0 || cov_map !== 8'hFF) begin
      errors++; $display("FAIL exh_results err=%0d cov=%h want 0/ff", err_cnt, cov_map);
    end
  endtask

  task automatic test_fault();
    step(3'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      step(v, (i == 0) ? 1'b1 : |v, 1'b1, 1'b0);
    end
    checks++;
    if (err_cnt !== 8'd1 || pass !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL fault err=%0d pass=%b done=%b want 1/0/1", err_cnt, pass, done);
    end
`ifdef TT_CHECK_FIRST_FAIL_EN
    checks++;
    if (ff_valid !== 1'b1 || ff_vec !== 3'd0) begin
      errors++; $display("FAIL first_fail valid=%b vec=%0d want 1/0", ff_valid, ff_vec);
    end
`endif
  endtask

  task automatic test_duplicates();
    logic [2:0] seq [10];
    seq = '{3'd1, 3'd1, 3'd1, 3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    step(3'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(seq[i], |seq[i], 1'b1, 1'b0);
      if (i == 8) begin
        checks++;
        if (done !== 1'b0) begin
          errors++; $display("FAIL dup_early done=%b want 0 after 9 accepts", done);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || err_cnt !== 8'd0 || pass !== 1'b1) begin
      errors++; $display("FAIL dup_done done=%b err=%0d pass=%b want 1/0/1", done, err_cnt, pass);
    end
  endtask

  task automatic test_reject();
    // After DONE: wrong outputs must be ignored.
    for (int i = 0; i < 3; i++) step(3'(i), ~(|3'(i)), 1'b1, 1'b0);
    checks++;
    if (err_cnt !== 8'd0 || cov_map !== 8'hFF || vec_ready !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL reject_done err=%0d cov=%h ready=%b done=%b want 0/ff/0/1", err_cnt, cov_map, vec_ready, done);
    end
    // Before any start (fresh from reset).
    rst_n = 1'b0; model_reset(); #2; @(negedge clk); rst_n = 1'b1; @(posedge clk); #1;
    for (int i = 0; i < 4; i++) step(3'(i), ~(|3'(i)), 1'b1, 1'b0);
    checks++;
    if (err_cnt !== 8'd0 || cov_map !== 8'h00 || vec_ready !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reject_idle err=%0d cov=%h ready=%b busy=%b want 0/00/0/0", err_cnt, cov_map, vec_ready, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    step(3'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(3'(i), ~(|3'(i)), 1'b1, 1'b0);
    checks++;
    if (cov_map !== 8'h0F || err_cnt !== exp_err8()) begin
      errors++; $display("FAIL midrun_pre cov=%h err=%0d want 0f/%0d", cov_map, err_cnt, exp_err8());
    end
    rst_n = 1'b0; model_reset();
    #2;
    checks++;
    if ({vec_ready, busy, done, pass} !== 4'b0000 || cov_map !== 8'h00 || err_cnt !== 8'h00) begin
      errors++; $display("FAIL midrun_reset flags=%b cov=%h err=%0d want 0000/00/0", {vec_ready, busy, done, pass}, cov_map, err_cnt);
    end
`ifdef TT_CHECK_FIRST_FAIL_EN
    checks++;
    if (ff_valid !== 1'b0 || ff_vec !== 3'd0) begin
      errors++; $display("FAIL midrun_ff valid=%b vec=%0d want 0/0", ff_valid, ff_vec);
    end
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_restart();
    step(3'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(3'(i), (i == 2) ? 1'b0 : |3'(i), 1'b1, 1'b0);
    checks++;
    if (cov_map !== 8'h0F || err_cnt !== 8'd1) begin
      errors++; $display("FAIL restart_pre cov=%h err=%0d want 0f/1", cov_map, err_cnt);
    end
    // Restart with a coincident wrong vector: it must be dropped.
    step(3'd7, 1'b0, 1'b1, 1'b1);
    checks++;
    if (cov_map !== 8'h00 || err_cnt !== 8'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL restart_clear cov=%h err=%0d busy=%b want 00/0/1", cov_map, err_cnt, busy);
    end
`ifdef TT_CHECK_FIRST_FAIL_EN
    checks++;
    if (ff_valid !== 1'b0) begin
      errors++; $display("FAIL restart_ff valid=%b want 0", ff_valid);
    end
`endif
  endtask

  task automatic test_saturation();
    step(3'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 7; i >= 0; i--) step(3'(i), ~(|3'(i)), 1'b1, 1'b0);
    checks++;
    if (s_err_cnt !== exp_err2() || s_pass !== 1'b0 || s_done !== 1'b1) begin
      errors++; $display("FAIL sat_cnt2 err=%0d pass=%b done=%b want %0d/0/1", s_err_cnt, s_pass, s_done, exp_err2());
    end
    checks++;
    if (err_cnt !== 8'd8 || pass !== 1'b0) begin
      errors++; $display("FAIL sat_cnt8 err=%0d pass=%b want 8/0", err_cnt, pass);
    end
`ifdef TT_CHECK_FIRST_FAIL_EN
    checks++;
    if (ff_valid !== 1'b1 || ff_vec !== 3'd7) begin
      errors++; $display("FAIL sat_ff valid=%b vec=%0d want 1/7", ff_valid, ff_vec);
    end
`endif
  endtask

  task automatic test_random();
    for (int run = 0; run < 20; run++) begin
      int cyc;
      step(3'd0, 1'b0, 1'b0, 1'b1);
      cyc = 0;
      while (!m_done && cyc < 150) begin
        logic [2:0] v;
        logic vld, strt, o;
        v    = 3'($urandom_range(0, 7));
        vld  = ($urandom_range(0, 3) != 0);
        strt = ($urandom_range(0, 59) == 0);
        o    = (|v) ^ ($urandom_range(0, 9) == 0);
        step(v, o, vld, strt);
        cyc++;
        checks++;
        if (cov_map !== m_cov || err_cnt !== exp_err8() || s_err_cnt !== exp_err2()) begin
          errors++; $display("FAIL rand_results run=%0d cyc=%0d cov=%h/%h err=%0d/%0d serr=%0d/%0d", run, cyc, cov_map, m_cov, err_cnt, exp_err8(), s_err_cnt, exp_err2());
        end
        checks++;
        if (done !== m_done || vec_ready !== m_run || busy !== m_run || pass !== (m_done && m_err == 0)) begin
          errors++; $display("FAIL rand_flags run=%0d cyc=%0d done=%b ready=%b busy=%b pass=%b want %b/%b/%b/%b", run, cyc, done, vec_ready, busy, pass, m_done, m_run, m_run, (m_done && m_err == 0));
        end
`ifdef TT_CHECK_FIRST_FAIL_EN
        checks++;
        if (ff_valid !== m_ffv || ff_vec !== m_ffvec) begin
          errors++; $display("FAIL rand_ff run=%0d valid=%b vec=%0d want %b/%0d", run, ff_valid, ff_vec, m_ffv, m_ffvec);
        end
`endif
      end
      checks++;
      if (!m_done) begin
        errors++; $display("FAIL rand_timeout run=%0d coverage %h not complete within budget", run, m_cov);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exhaustive();
    test_fault();
    test_duplicates();
    test_reject();
    test_reset_mid_run();
    test_restart();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
